// File: rtl/irq_sequencer.sv
// -----------------------------------------------------------------------------
// irq_sequencer
//
// Interrupt sequencer for the pipelined MIPS core. Rising edges on the
// peripheral/timer interrupt lines are latched as pending requests. The block
// waits for a safe instruction in ID, then injects a one-cycle interrupt
// entry: it tells the decoder to treat the ID instruction as the interrupt,
// squashes the fetch in flight and steers the PC mux to the handler vector.
// After entry it holds kernel mode until the handler's return instruction
// (jr $26) is accepted in ID. There is no nesting.
//
// State    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | user mode, no unmasked request seen yet
// WAIT_SAFE| unmasked request present, waiting for a safe ID instruction
// TAKE     | one-cycle entry: irq/flush_if/pc_sel_vec/irq_ack asserted
// KERNEL   | handler running; new edges only accumulate in pending
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   irq_src      level interrupt lines (edge-detected here), index 0 highest
//   irq_mask     1 = source masked; its pending bit still records edges
//   id_valid     ID holds a real instruction (not a bubble)
//   id_pc        PC of the instruction in ID
//   id_stall     load-use stall holding ID this cycle
//   ex_redirect  taken branch/jump resolving in EX (ID about to be flushed)
//   id_is_eret   ID holds the handler return
//   irq          decoder: ID instruction becomes the interrupt entry
//   flush_if     squash the IF/ID fetch in flight
//   pc_sel_vec   PC mux selects vec_pc
//   vec_pc       handler entry PC (constant VECTOR)
//   epc          PC of the interrupted instruction
//   cause        one-hot source of the last taken interrupt
//   irq_ack      one-cycle acknowledge pulse to the serviced source
//   kernel_mode  high from interrupt entry until the return is accepted
// -----------------------------------------------------------------------------
module irq_sequencer #(
    parameter int          NUM_SRC = 4,
    parameter logic [31:0] VECTOR  = 32'h80000004
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               id_valid,
    input  logic [31:0]        id_pc,
    input  logic               id_stall,
    input  logic               ex_redirect,
    input  logic               id_is_eret,
    output logic               irq,
    output logic               flush_if,
    output logic               pc_sel_vec,
    output logic [31:0]        vec_pc,
    output logic [31:0]        epc,
    output logic [NUM_SRC-1:0] cause,
    output logic [NUM_SRC-1:0] irq_ack,
    output logic               kernel_mode
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SAFE = 2'd1,
        TAKE      = 2'd2,
        KERNEL    = 2'd3
    } seqStateT;

    seqStateT           state;
    logic [NUM_SRC-1:0] srcPrev;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] selOneHot;
    logic               safePoint;
    logic               eretAccept;

    assign vec_pc = VECTOR;

    assign rise       = irq_src & ~srcPrev;
    assign req        = pending & ~irq_mask;
    assign safePoint  = id_valid & ~id_stall & ~ex_redirect & ~id_is_eret;
    assign eretAccept = id_is_eret & id_valid & ~id_stall;

    // Lowest set index of req wins.
    always_comb begin
        selOneHot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                selOneHot    = '0;
                selOneHot[i] = 1'b1;
            end
        end
    end

    // irq_ack is only non-zero during TAKE and carries the source chosen on
    // entry, so it doubles as the pending-clear mask. A fresh edge in the
    // same cycle wins over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            srcPrev <= '0;
            pending <= '0;
        end else begin
            srcPrev <= irq_src;
            pending <= (pending & ~irq_ack) | rise;
        end
    end

    // The source is frozen on the WAIT_SAFE->TAKE edge so the TAKE outputs
    // can be registered; cause and the pending clear reuse that choice.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            irq         <= 1'b0;
            flush_if    <= 1'b0;
            pc_sel_vec  <= 1'b0;
            irq_ack     <= '0;
            kernel_mode <= 1'b0;
            epc         <= '0;
            cause       <= '0;
        end else begin
            irq        <= 1'b0;
            flush_if   <= 1'b0;
            pc_sel_vec <= 1'b0;
            irq_ack    <= '0;

            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= WAIT_SAFE;
                    end
                end

                WAIT_SAFE: begin
                    if (req == '0) begin
                        state <= IDLE;
                    end else if (safePoint) begin
                        state      <= TAKE;
                        irq        <= 1'b1;
                        flush_if   <= 1'b1;
                        pc_sel_vec <= 1'b1;
                        irq_ack    <= selOneHot;
                    end
                end

                TAKE: begin
                    state       <= KERNEL;
                    epc         <= id_pc;
                    cause       <= irq_ack;
                    kernel_mode <= 1'b1;
                end

                KERNEL: begin
                    // Returning always lands in IDLE; a request still pending
                    // is picked up from there one cycle later.
                    if (eretAccept) begin
                        state       <= IDLE;
                        kernel_mode <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    kernel_mode <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irq_sequencer
//
// Directed scenarios followed by randomized traffic. A behavioural model
// advances once per clock from the driven inputs; each predicted interrupt
// entry pushes its acknowledge pattern into a queue that a separate monitor
// pops whenever the DUT raises irq. Every output is also compared against
// the model once per cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_irq_sequencer;

    localparam int          N   = 4;
    localparam logic [31:0] VEC = 32'h80000004;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_src;
    logic [N-1:0]  irq_mask;
    logic          id_valid;
    logic [31:0]   id_pc;
    logic          id_stall;
    logic          ex_redirect;
    logic          id_is_eret;
    logic          irq;
    logic          flush_if;
    logic          pc_sel_vec;
    logic [31:0]   vec_pc;
    logic [31:0]   epc;
    logic [N-1:0]  cause;
    logic [N-1:0]  irq_ack;
    logic          kernel_mode;

    irq_sequencer #(.NUM_SRC(N), .VECTOR(VEC)) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_src     (irq_src),
        .irq_mask    (irq_mask),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_stall    (id_stall),
        .ex_redirect (ex_redirect),
        .id_is_eret  (id_is_eret),
        .irq         (irq),
        .flush_if    (flush_if),
        .pc_sel_vec  (pc_sel_vec),
        .vec_pc      (vec_pc),
        .epc         (epc),
        .cause       (cause),
        .irq_ack     (irq_ack),
        .kernel_mode (kernel_mode)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    logic [N-1:0] sb[$];

    // Reference model: pending edges as a bit vector, the sequencer's
    // progress as a few plain flags, the chosen source as an integer index.
    logic [N-1:0] mPend;
    logic [N-1:0] mPrevSrc;
    bit           mSeeking;
    bit           mTaking;
    bit           mKernel;
    int           mTakeIdx;
    logic [31:0]  mEpc;
    logic [N-1:0] mCause;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nVec++;
        if (act !== expv) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int lowestIdx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oneHot(input int idx);
        logic [N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        mPend    = '0;
        mPrevSrc = '0;
        mSeeking = 1'b0;
        mTaking  = 1'b0;
        mKernel  = 1'b0;
        mTakeIdx = 0;
        mEpc     = '0;
        mCause   = '0;
        sb.delete();
    endtask

    // What the coming rising edge does, given the inputs now on the pins.
    task automatic model_edge();
        logic [N-1:0] req;
        logic [N-1:0] nextPend;
        bit           safe;
        req      = mPend & ~irq_mask;
        safe     = id_valid && !id_stall && !ex_redirect && !id_is_eret;
        nextPend = mPend;
        if (mTaking) nextPend[mTakeIdx] = 1'b0;
        nextPend = nextPend | (irq_src & ~mPrevSrc);

        if (mTaking) begin
            mTaking = 1'b0;
            mKernel = 1'b1;
            mEpc    = id_pc;
            mCause  = oneHot(mTakeIdx);
        end else if (mKernel) begin
            if (id_is_eret && id_valid && !id_stall) mKernel = 1'b0;
        end else if (mSeeking) begin
            if (req == '0) begin
                mSeeking = 1'b0;
            end else if (safe) begin
                mSeeking = 1'b0;
                mTaking  = 1'b1;
                mTakeIdx = lowestIdx(req);
                sb.push_back(oneHot(mTakeIdx));
            end
        end else if (req != '0) begin
            mSeeking = 1'b1;
        end

        mPend    = nextPend;
        mPrevSrc = irq_src;
    endtask

    task automatic check_outputs();
        chk("irq",         irq,         mTaking);
        chk("flush_if",    flush_if,    mTaking);
        chk("pc_sel_vec",  pc_sel_vec,  mTaking);
        chk("irq_ack",     irq_ack,     mTaking ? oneHot(mTakeIdx) : '0);
        chk("kernel_mode", kernel_mode, mKernel);
        chk("epc",         epc,         mEpc);
        chk("cause",       cause,       mCause);
        chk("vec_pc",      vec_pc,      VEC);
    endtask

    // Called at a falling edge with inputs already set.
    task automatic step();
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_in(input logic [N-1:0] src, input logic [N-1:0] msk,
                          input logic vld, input logic [31:0] pc,
                          input logic stl, input logic rdr, input logic ert);
        irq_src     = src;
        irq_mask    = msk;
        id_valid    = vld;
        id_pc       = pc;
        id_stall    = stl;
        ex_redirect = rdr;
        id_is_eret  = ert;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_irq",         irq,         1'b0);
        chk("rst_flush_if",    flush_if,    1'b0);
        chk("rst_pc_sel_vec",  pc_sel_vec,  1'b0);
        chk("rst_irq_ack",     irq_ack,     '0);
        chk("rst_kernel_mode", kernel_mode, 1'b0);
        chk("rst_epc",         epc,         '0);
        chk("rst_cause",       cause,       '0);
        chk("rst_vec_pc",      vec_pc,      VEC);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Scoreboard monitor, sampling just after each rising edge.
    initial begin
        logic [N-1:0] expAck;
        forever begin
            @(posedge clk);
            #2;
            if (irq === 1'b1) begin
                if (sb.size() == 0) begin
                    nVec++;
                    nErr++;
                    $display("FAIL sb_unexpected_irq: ack %b with no entry expected (t=%0t)", irq_ack, $time);
                end else begin
                    expAck = sb.pop_front();
                    chk("sb_ack",        irq_ack,    expAck);
                    chk("sb_flush_if",   flush_if,   1'b1);
                    chk("sb_pc_sel_vec", pc_sel_vec, 1'b1);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] src;
        logic [N-1:0] msk;
        reset = 1'b0;
        set_in('0, '0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic entry: TAKE on the third edge.
        set_in(4'b0100, '0, 1'b1, 32'h00400010, 1'b0, 1'b0, 1'b0);
        step(); step(); step();
        chk("basic_irq", irq, 1'b1);
        chk("basic_ack", irq_ack, 4'b0100);
        step();
        chk("basic_epc", epc, 32'h00400010);
        chk("basic_cause", cause, 4'b0100);
        chk("basic_kernel", kernel_mode, 1'b1);
        id_is_eret = 1'b1;
        step();
        chk("basic_return", kernel_mode, 1'b0);
        set_in('0, '0, 1'b1, 32'h00400020, 1'b0, 1'b0, 1'b0);
        step(); step();

        // Safe-point wait: bubble, 3 stalls, 1 redirect, then safe.
        set_in(4'b0001, '0, 1'b0, 32'h00400100, 1'b0, 1'b0, 1'b0);
        step(); step();
        id_valid = 1'b1;
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_stall_noirq", irq, 1'b0);
        end
        id_stall    = 1'b0;
        ex_redirect = 1'b1;
        step();
        chk("wait_redirect_noirq", irq, 1'b0);
        ex_redirect = 1'b0;
        step();
        chk("wait_take_irq", irq, 1'b1);
        chk("wait_take_ack", irq_ack, 4'b0001);
        step();
        chk("wait_epc", epc, 32'h00400100);
        set_in('0, '0, 1'b1, 32'h80000010, 1'b0, 1'b0, 1'b1);
        step();
        id_is_eret = 1'b0;

        // Priority and no nesting.
        set_in(4'b1010, '0, 1'b1, 32'h00400200, 1'b0, 1'b0, 1'b0);
        step(); step(); step();
        chk("prio_ack", irq_ack, 4'b0010);
        step();
        chk("prio_cause", cause, 4'b0010);
        irq_src = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("prio_nonest", irq, 1'b0);
        end
        id_is_eret = 1'b1;
        step();
        chk("prio_ret_kernel", kernel_mode, 1'b0);
        chk("prio_ret_noirq", irq, 1'b0);
        id_is_eret = 1'b0;
        step();
        chk("prio_ret_wait_noirq", irq, 1'b0);
        step();
        chk("prio_second_irq", irq, 1'b1);
        chk("prio_second_ack", irq_ack, 4'b1000);
        step();
        chk("prio_second_cause", cause, 4'b1000);
        id_is_eret = 1'b1;
        step();
        id_is_eret = 1'b0;

        // Mask retreat.
        set_in(4'b0100, '0, 1'b0, 32'h00400300, 1'b0, 1'b0, 1'b0);
        step(); step();
        irq_mask = 4'b0100;
        step();
        chk("mask_noack", irq_ack, '0);
        id_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("mask_noirq", irq, 1'b0);
        end
        irq_mask = '0;
        step(); step();
        chk("unmask_ack", irq_ack, 4'b0100);
        irq_src = '0;
        step();
        chk("unmask_cause", cause, 4'b0100);
        id_is_eret = 1'b1;
        step();
        id_is_eret = 1'b0;

        // Edge/ack collision: source 0 re-rises during its own TAKE.
        set_in(4'b0001, '0, 1'b0, 32'h00400400, 1'b0, 1'b0, 1'b0);
        step(); step();
        irq_src  = '0;
        id_valid = 1'b1;
        step();
        chk("coll_take_ack", irq_ack, 4'b0001);
        irq_src = 4'b0001;
        step();
        id_is_eret = 1'b1;
        step();
        id_is_eret = 1'b0;
        step(); step();
        chk("coll_retake_irq", irq, 1'b1);
        chk("coll_retake_ack", irq_ack, 4'b0001);
        step();
        irq_src = '0;
        step();
        irq_src = 4'b0010;
        step();

        // Reset in KERNEL with source 1 pending.
        irq_src = '0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_reset_noirq", irq, 1'b0);
        end

        // Randomized traffic.
        src = '0;
        msk = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0)  src[b] = ~src[b];
                if ($urandom_range(0, 19) == 0) msk[b] = ~msk[b];
            end
            set_in(src, msk,
                   $urandom_range(0, 99) < 85,
                   {$urandom} & 32'hFFFF_FFFC,
                   $urandom_range(0, 99) < 20,
                   $urandom_range(0, 99) < 10,
                   $urandom_range(0, 99) < 15);
            step();
        end

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
